// File: rtl/slu_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : slu_bus_master
//  Description : Clocked initiator for the SLU 8-bit parallel relay-card bus.
//                Turns single-beat read/write requests into bus cycles with
//                programmable setup / strobe / hold timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module slu_bus_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw_n,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       bus_rw_n,
    output logic       bus_strobe,
    output logic [7:0] bus_address,
    inout  wire  [7:0] bus_data
);

    // One shared down-counter sized for the longest phase.
    localparam int c_MAX_CYC = (SETUP_CYC > STROBE_CYC) ?
                               ((SETUP_CYC  > HOLD_CYC) ? SETUP_CYC  : HOLD_CYC) :
                               ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int c_CNT_W = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_SETUP_LD  = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STROBE_LD = c_CNT_W'(STROBE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD   = c_CNT_W'(HOLD_CYC - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETUP  = 3'd1;
    localparam logic [2:0] c_ST_STROBE = 3'd2;
    localparam logic [2:0] c_ST_HOLD   = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    // Reject timing parameters the bus protocol cannot honour.
    generate
        if (SETUP_CYC < 2) begin : g_bad_setup
            $error("slu_bus_master: SETUP_CYC must be >= 2");
        end
        if (STROBE_CYC < 1) begin : g_bad_strobe
            $error("slu_bus_master: STROBE_CYC must be >= 1");
        end
        if (HOLD_CYC < 1) begin : g_bad_hold
            $error("slu_bus_master: HOLD_CYC must be >= 1");
        end
    endgenerate

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic               r_rw_n;
    logic [7:0]         r_addr;
    logic [7:0]         r_wdata;
    logic               r_drive_en;
    logic               r_bus_rw_n;
    logic               r_bus_strobe;
    logic               r_rsp_valid;
    logic [7:0]         r_rsp_rdata;

    logic               w_accept;
    logic               w_rw_sel;
    logic               w_bus_phase_nxt;
    logic               w_bus_rw_n_nxt;
    logic               w_drive_nxt;
    logic               w_strobe_nxt;
    logic               w_rsp_nxt;
    logic               w_sample;

    assign w_accept = (r_state == c_ST_IDLE) && req_valid;

    // Next-state, phase counter and next values of the registered bus outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = c_ST_SETUP;
                    w_cnt_nxt   = c_SETUP_LD;
                end
            end
            c_ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_STROBE;
                    w_cnt_nxt   = c_STROBE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = c_HOLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Direction comes straight from the request on the accepting edge,
        // otherwise from the latched copy.
        w_rw_sel        = (r_state == c_ST_IDLE) ? req_rw_n : r_rw_n;
        w_bus_phase_nxt = (w_state_nxt == c_ST_SETUP)  ||
                          (w_state_nxt == c_ST_STROBE) ||
                          (w_state_nxt == c_ST_HOLD);
        w_bus_rw_n_nxt  = w_bus_phase_nxt ? w_rw_sel : 1'b1;
        // Write data is withheld for the first SETUP cycle so the card has
        // one dead cycle to release the bus after rw_n falls.
        w_drive_nxt     = !r_rw_n &&
                          (((r_state == c_ST_SETUP) && (w_state_nxt == c_ST_SETUP)) ||
                           (w_state_nxt == c_ST_STROBE) ||
                           (w_state_nxt == c_ST_HOLD));
        w_strobe_nxt    = (w_state_nxt == c_ST_STROBE);
        w_rsp_nxt       = (w_state_nxt == c_ST_DONE);
        w_sample        = (r_state == c_ST_STROBE) && (r_cnt == '0) && r_rw_n;
    end

    // State register, request latch and registered bus/response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_rw_n       <= 1'b1;
            r_addr       <= 8'h00;
            r_wdata      <= 8'h00;
            r_drive_en   <= 1'b0;
            r_bus_rw_n   <= 1'b1;
            r_bus_strobe <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_drive_en   <= w_drive_nxt;
            r_bus_rw_n   <= w_bus_rw_n_nxt;
            r_bus_strobe <= w_strobe_nxt;
            r_rsp_valid  <= w_rsp_nxt;
            if (w_accept) begin
                r_rw_n  <= req_rw_n;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_sample) begin
                r_rsp_rdata <= bus_data;
            end
        end
    end

    assign req_ready   = (r_state == c_ST_IDLE);
    assign busy        = (r_state != c_ST_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign bus_rw_n    = r_bus_rw_n;
    assign bus_strobe  = r_bus_strobe;
    assign bus_address = r_addr;
    assign bus_data    = r_drive_en ? r_wdata : 8'hzz;

    // The master must never fight the card, which drives whenever rw_n is high.
    a_no_contention: assert property (@(posedge clk) disable iff (reset)
                                      !(r_drive_en && r_bus_rw_n));

endmodule
`default_nettype wire

// File: tb/tb_slu_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slu_bus_master
//  Description : Self-checking bench for slu_bus_master with a relay-card
//                responder model on the shared data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slu_bus_master;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw_n;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       bus_rw_n;
    logic       bus_strobe;
    logic [7:0] bus_address;
    wire  [7:0] bus_data;

    logic       d2_req_valid;
    logic       d2_req_ready;
    logic       d2_req_rw_n;
    logic [7:0] d2_req_addr;
    logic [7:0] d2_req_wdata;
    logic       d2_rsp_valid;
    logic [7:0] d2_rsp_rdata;
    logic       d2_busy;
    logic       d2_bus_rw_n;
    logic       d2_bus_strobe;
    logic [7:0] d2_bus_address;
    wire  [7:0] d2_bus_data;

    int n_tests = 0;
    int n_fail  = 0;

    slu_bus_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw_n(req_rw_n),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .bus_rw_n(bus_rw_n), .bus_strobe(bus_strobe),
        .bus_address(bus_address), .bus_data(bus_data)
    );

    slu_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(d2_req_valid), .req_ready(d2_req_ready), .req_rw_n(d2_req_rw_n),
        .req_addr(d2_req_addr), .req_wdata(d2_req_wdata),
        .rsp_valid(d2_rsp_valid), .rsp_rdata(d2_rsp_rdata), .busy(d2_busy),
        .bus_rw_n(d2_bus_rw_n), .bus_strobe(d2_bus_strobe),
        .bus_address(d2_bus_address), .bus_data(d2_bus_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Card responder: drives register contents while strobed for a read,
    // latches bus data on the strobe rising edge for a write.
    logic [7:0] card_regs [0:255];
    initial begin
        for (int i = 0; i < 256; i++) card_regs[i] = 8'h00;
        card_regs[8'h00] = 8'h43;
        card_regs[8'h01] = 8'h10;
        card_regs[8'h02] = 8'h01;
        card_regs[8'h03] = 8'h55;
        card_regs[8'h04] = 8'hAA;
        card_regs[8'h05] = 8'h00;
    end
    assign bus_data = (bus_strobe && bus_rw_n) ? card_regs[bus_address] : 8'hzz;
    always @(posedge bus_strobe) begin
        if (!bus_rw_n) card_regs[bus_address] <= bus_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request on the default-timing DUT; returns the acceptance-to-
    // response latency in cycles and the number of cycles strobe was high.
    task automatic run_txn(input logic rw, input logic [7:0] a, input logic [7:0] wd,
                           output int lat, output int sw);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_rw_n = rw; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        sw  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus_strobe) sw++;
        end while (!rsp_valid && lat < 40);
    endtask

    typedef struct {
        logic       rw_n;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat, sw, first, second, extra, guard;
        logic [7:0] rd1, rd2;

        // read: expected data; write: rsp_rdata holds the last read value
        vecs[0] = '{1'b1, 8'h00, 8'h00, 8'h43};
        vecs[1] = '{1'b0, 8'h05, 8'h83, 8'h43};
        vecs[2] = '{1'b1, 8'h05, 8'h00, 8'h83};
        vecs[3] = '{1'b1, 8'h02, 8'h00, 8'h01};
        vecs[4] = '{1'b0, 8'h01, 8'h3C, 8'h01};
        vecs[5] = '{1'b1, 8'h01, 8'h00, 8'h3C};
        vecs[6] = '{1'b1, 8'h03, 8'h00, 8'h55};

        reset = 1'b1;
        req_valid = 1'b0; req_rw_n = 1'b1; req_addr = 8'h00; req_wdata = 8'h00;
        d2_req_valid = 1'b0; d2_req_rw_n = 1'b1; d2_req_addr = 8'h00; d2_req_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_strobe",  {31'd0, bus_strobe}, 32'd0);
        check("rst_rw_n",    {31'd0, bus_rw_n},   32'd1);
        check("rst_addr",    {24'd0, bus_address}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata",   {24'd0, rsp_rdata},  32'd0);
        check("rst_busy",    {31'd0, busy},       32'd0);
        check("rst_ready",   {31'd0, req_ready},  32'd1);

        // Table-driven single transfers at default timing.
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].rw_n, vecs[i].addr, vecs[i].wdata, lat, sw);
            check($sformatf("v%0d_latency", i), lat, 6);
            check($sformatf("v%0d_strobe_width", i), sw, 2);
            check($sformatf("v%0d_rdata", i), {24'd0, rsp_rdata}, {24'd0, vecs[i].exp_rdata});
            @(negedge clk);
            check($sformatf("v%0d_rsp_pulse", i), {31'd0, rsp_valid}, 32'd0);
        end

        // Back-to-back reads with req_valid held high.
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_rw_n = 1'b1; req_addr = 8'h03;
        @(posedge clk); #1;
        req_addr = 8'h04;
        first = 0; second = 0; extra = 0; rd1 = 8'h00; rd2 = 8'h00;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (first == 0) begin
                    first = c; rd1 = rsp_rdata;
                end else if (second == 0) begin
                    second = c; rd2 = rsp_rdata; req_valid = 1'b0;
                end else begin
                    extra++;
                end
            end
        end
        req_valid = 1'b0;
        check("b2b_first_cycle",  first,  6);
        check("b2b_second_cycle", second, 13);
        check("b2b_first_data",   {24'd0, rd1}, 32'h55);
        check("b2b_second_data",  {24'd0, rd2}, 32'hAA);
        check("b2b_no_extra",     extra,  0);
        check("b2b_idle_after",   {31'd0, busy}, 32'd0);

        // Read followed by a write: data bus turnaround.
        run_txn(1'b1, 8'h00, 8'h00, lat, sw);
        check("ta_read_data", {24'd0, rsp_rdata}, 32'h43);
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_rw_n = 1'b0; req_addr = 8'h05; req_wdata = 8'h83;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("ta_setup1_rw_n",    {31'd0, bus_rw_n}, 32'd0);
        check("ta_setup1_released", {31'd0, (bus_data === 8'h83)}, 32'd0);
        @(negedge clk);
        check("ta_setup2_data",    {24'd0, bus_data}, 32'h83);
        check("ta_setup2_strobe",  {31'd0, bus_strobe}, 32'd0);
        @(negedge clk);
        check("ta_strobe_data",    {24'd0, bus_data}, 32'h83);
        check("ta_strobe_high",    {31'd0, bus_strobe}, 32'd1);
        guard = 0;
        while (!rsp_valid && guard < 40) begin @(negedge clk); guard++; end
        check("ta_write_done", {31'd0, rsp_valid}, 32'd1);
        check("ta_card_reg", {24'd0, card_regs[8'h05]}, 32'h83);

        // Reset asserted during the first STROBE cycle of a write.
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_rw_n = 1'b0; req_addr = 8'h02; req_wdata = 8'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rm_strobe_before", {31'd0, bus_strobe}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rm_strobe",   {31'd0, bus_strobe}, 32'd0);
        check("rm_rw_n",     {31'd0, bus_rw_n},   32'd1);
        check("rm_released", {31'd0, (bus_data === 8'h5A)}, 32'd0);
        check("rm_busy",     {31'd0, busy},       32'd0);
        check("rm_ready",    {31'd0, req_ready},  32'd1);
        check("rm_rdata",    {24'd0, rsp_rdata},  32'd0);
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid || bus_strobe) extra++;
            @(negedge clk);
        end
        check("rm_no_rsp_no_strobe", extra, 0);

        // Non-default timing instance: S=3, T=4, H=2.
        @(negedge clk);
        d2_req_valid = 1'b1; d2_req_rw_n = 1'b0; d2_req_addr = 8'h07; d2_req_wdata = 8'h11;
        @(posedge clk); #1;
        d2_req_valid = 1'b0;
        lat = 0; sw = 0;
        do begin
            @(negedge clk);
            lat++;
            if (d2_bus_strobe) sw++;
        end while (!d2_rsp_valid && lat < 40);
        check("p_latency",      lat, 10);
        check("p_strobe_width", sw,  4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
